// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_mmio
//  Description : Data-side responder for the single-cycle core. Serves a word
//                RAM at byte address 0 and a 16-byte MMIO page at MMIO_BASE
//                (LED register, free-running timer with compare/match flag).
//                Reads are combinational; writes take effect on the rising
//                edge of clk. Misaligned writes and unmapped accesses are
//                dropped; unmapped reads return zero.
//  Ports       : clk       - single clock
//                rst       - synchronous active-high reset
//                MemWrite  - write strobe, sampled on rising clk
//                Addr      - byte address (word index = Addr[31:2])
//                WriteData - store data
//                ReadData  - combinational read data for Addr
//                Leds      - LED register contents
//                TimerIrq  - level copy of STATUS.MATCH
//  Macro       : DMEM_TIMER_EN - when defined, TIMER/COMPARE/STATUS exist;
//                when undefined those offsets read 0 and TimerIrq is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio #(
    parameter int          RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000FF00,
    parameter int          LED_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemWrite,
    input  logic [31:0]      Addr,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    output logic [LED_W-1:0] Leds,
    output logic             TimerIrq
);

    localparam int          c_RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] c_RAM_BYTES = 32'(RAM_WORDS * 4);

    localparam logic [1:0]  c_OFF_LED     = 2'd0;
    localparam logic [1:0]  c_OFF_TIMER   = 2'd1;
    localparam logic [1:0]  c_OFF_COMPARE = 2'd2;
    localparam logic [1:0]  c_OFF_STATUS  = 2'd3;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic                w_ram_sel;
    logic                w_mmio_sel;
    logic                w_wr_ok;
    logic [c_RAM_AW-1:0] w_ram_idx;
    logic [1:0]          w_reg_off;

    assign w_ram_sel  = (Addr < c_RAM_BYTES);
    // The page is 16 bytes; byte lanes inside a word are ignored on reads.
    assign w_mmio_sel = (Addr[31:4] == MMIO_BASE[31:4]);
    assign w_wr_ok    = MemWrite && (Addr[1:0] == 2'b00);
    assign w_ram_idx  = Addr[c_RAM_AW+1:2];
    assign w_reg_off  = Addr[3:2];

    logic w_wr_led;
    logic w_wr_timer;
    logic w_wr_compare;
    logic w_wr_status;

    assign w_wr_led     = w_wr_ok && w_mmio_sel && (w_reg_off == c_OFF_LED);
    assign w_wr_timer   = w_wr_ok && w_mmio_sel && (w_reg_off == c_OFF_TIMER);
    assign w_wr_compare = w_wr_ok && w_mmio_sel && (w_reg_off == c_OFF_COMPARE);
    assign w_wr_status  = w_wr_ok && w_mmio_sel && (w_reg_off == c_OFF_STATUS);

    // ------------------------------------------------------------------------
    // Word RAM (contents intentionally not reset)
    // ------------------------------------------------------------------------
    logic [31:0] r_ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (w_wr_ok && w_ram_sel) begin
            r_ram[w_ram_idx] <= WriteData;
        end
    end

    // ------------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------------
    logic [LED_W-1:0] r_leds;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds <= '0;
        end else if (w_wr_led) begin
            r_leds <= WriteData[LED_W-1:0];
        end
    end

    assign Leds = r_leds;

    // ------------------------------------------------------------------------
    // Timer block
    // ------------------------------------------------------------------------
    logic [31:0] w_timer_rd;
    logic [31:0] w_compare_rd;
    logic [31:0] w_status_rd;

`ifdef DMEM_TIMER_EN
    logic [31:0] r_timer;
    logic [31:0] r_compare;
    logic        r_en;
    logic        r_match;
    logic        w_hit;

    // Compare against the pre-increment, pre-write count.
    assign w_hit = r_en && (r_timer == r_compare);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer   <= 32'h0;
            r_compare <= 32'hFFFF_FFFF;
            r_en      <= 1'b0;
            r_match   <= 1'b0;
        end else begin
            // A CPU load of TIMER wins over the increment in the same cycle.
            if (w_wr_timer) begin
                r_timer <= WriteData;
            end else if (r_en) begin
                r_timer <= r_timer + 32'h1;
            end

            if (w_wr_compare) begin
                r_compare <= WriteData;
            end

            if (w_wr_status) begin
                r_en <= WriteData[1];
            end

            // A new match beats a simultaneous write-1-to-clear.
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_wr_status && WriteData[0]) begin
                r_match <= 1'b0;
            end
        end
    end

    assign w_timer_rd   = r_timer;
    assign w_compare_rd = r_compare;
    assign w_status_rd  = {30'h0, r_en, r_match};
    assign TimerIrq     = r_match;
`else
    assign w_timer_rd   = 32'h0;
    assign w_compare_rd = 32'h0;
    assign w_status_rd  = 32'h0;
    assign TimerIrq     = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------------
    always_comb begin
        ReadData = 32'h0;
        if (w_ram_sel) begin
            ReadData = r_ram[w_ram_idx];
        end else if (w_mmio_sel) begin
            case (w_reg_off)
                c_OFF_LED:     ReadData = 32'(r_leds);
                c_OFF_TIMER:   ReadData = w_timer_rd;
                c_OFF_COMPARE: ReadData = w_compare_rd;
                c_OFF_STATUS:  ReadData = w_status_rd;
                default:       ReadData = 32'h0;
            endcase
        end
    end

endmodule
`default_nettype wire
